// File: rtl/tetris_board_render.sv
// tetris_board_render
//   Pixel source feeding the VGA output stage. The board is a COLS x ROWS grid of
//   4-bit colour indices held in two banks: one is displayed, the other is written
//   by game logic. A commit publishes the write bank at the next frame start.
//
//   Optional build macro: GRID_LINE_EN draws 404040 grid lines on the top and left
//   pixel edges of empty cells.
//
// Ports
//   clk, rst_n           pixel clock, synchronous active-low reset
//   i_x, i_y, i_de       display coordinate stream
//   i_frame_start        one-cycle pulse at the start of vertical blank
//   i_wr_en/col/row/color  cell write into the write bank
//   i_commit             request to swap banks at the next frame start
//   o_busy               writes and commits are ignored while high
//   o_commit_ack         one-cycle pulse on the bank swap
//   o_r, o_g, o_b, o_de  pixel colour and display enable, 2 cycles after input
module tetris_board_render (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    input  logic       i_de,
    input  logic       i_frame_start,
    input  logic       i_wr_en,
    input  logic [3:0] i_wr_col,
    input  logic [4:0] i_wr_row,
    input  logic [3:0] i_wr_color,
    input  logic       i_commit,
    output logic       o_busy,
    output logic       o_commit_ack,
    output logic [7:0] o_r,
    output logic [7:0] o_g,
    output logic [7:0] o_b,
    output logic       o_de
);

    localparam int unsigned BOARD_X0  = 240;
    localparam int unsigned BOARD_Y0  = 80;
    localparam int unsigned CELL_LOG2 = 4;
    localparam int unsigned COLS      = 10;
    localparam int unsigned ROWS      = 20;
    localparam int unsigned CELLS     = COLS * ROWS;
    localparam int unsigned AW        = 8;
    localparam int unsigned BOARD_W   = COLS << CELL_LOG2;
    localparam int unsigned BOARD_H   = ROWS << CELL_LOG2;
    localparam logic [23:0] BORDER_RGB = 24'h202020;
`ifdef GRID_LINE_EN
    localparam logic [23:0] GRID_RGB   = 24'h404040;
`endif

    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_PENDING} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_addr_q, clr_addr_d;
    logic            disp_sel_q, disp_sel_d;
    logic            busy_q, busy_d;
    logic            ack_q, ack_d;

    logic            we0_c, we1_c;
    logic [AW-1:0]   waddr_c;
    logic [3:0]      wdata_c;
    logic            wr_ok_c;
    logic [AW-1:0]   wr_addr_c;

    logic [3:0]      bank0_q [CELLS];
    logic [3:0]      bank1_q [CELLS];

    // Control state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            disp_sel_q <= 1'b0;
            busy_q     <= 1'b1;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            disp_sel_q <= disp_sel_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
        end
    end

    assign wr_ok_c   = (i_wr_col < 4'(COLS)) && (i_wr_row < 5'(ROWS));
    assign wr_addr_c = AW'(i_wr_row) * AW'(COLS) + AW'(i_wr_col);

    // Next-state logic and bank write port control
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        disp_sel_d = disp_sel_q;
        ack_d      = 1'b0;
        we0_c      = 1'b0;
        we1_c      = 1'b0;
        waddr_c    = clr_addr_q;
        wdata_c    = '0;
        unique case (state_q)
            ST_CLEAR: begin
                we0_c      = 1'b1;
                we1_c      = 1'b1;
                clr_addr_d = clr_addr_q + AW'(1);
                if (clr_addr_q == AW'(CELLS - 1)) begin
                    clr_addr_d = '0;
                    state_d    = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (i_wr_en && wr_ok_c) begin
                    waddr_c = wr_addr_c;
                    wdata_c = i_wr_color;
                    we0_c   = disp_sel_q;
                    we1_c   = ~disp_sel_q;
                end
                if (i_commit) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                if (i_frame_start) begin
                    disp_sel_d = ~disp_sel_q;
                    ack_d      = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Bank memories: one write port each, no reset (cleared by the FSM)
    always_ff @(posedge clk) begin
        if (we0_c) bank0_q[waddr_c] <= wdata_c;
        if (we1_c) bank1_q[waddr_c] <= wdata_c;
    end

    // Pixel stage 1: board-relative coordinates and cell address
    logic [10:0]   dx_c, dy_c;
    logic          inside_c;
    logic [AW-1:0] addr_c;
    logic [AW-1:0] s1_addr_q;
    logic          s1_inside_q, s1_de_q;

    // Coordinates left/above the board wrap to values with bit 10 set
    assign dx_c     = {1'b0, i_x} - 11'(BOARD_X0);
    assign dy_c     = {1'b0, i_y} - 11'(BOARD_Y0);
    assign inside_c = i_de && !dx_c[10] && !dy_c[10]
                      && (dx_c < 11'(BOARD_W)) && (dy_c < 11'(BOARD_H));
    assign addr_c   = AW'(dy_c[10:CELL_LOG2]) * AW'(COLS) + AW'(dx_c[10:CELL_LOG2]);

`ifdef GRID_LINE_EN
    logic s1_grid_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_addr_q   <= '0;
            s1_inside_q <= 1'b0;
            s1_de_q     <= 1'b0;
`ifdef GRID_LINE_EN
            s1_grid_q   <= 1'b0;
`endif
        end else begin
            s1_addr_q   <= inside_c ? addr_c : '0;
            s1_inside_q <= inside_c;
            s1_de_q     <= i_de;
`ifdef GRID_LINE_EN
            s1_grid_q   <= (dx_c[CELL_LOG2-1:0] == '0) || (dy_c[CELL_LOG2-1:0] == '0);
`endif
        end
    end

    function automatic logic [23:0] palette(input logic [3:0] idx);
        case (idx)
            4'd0:    palette = 24'h000000;
            4'd1:    palette = 24'h00FFFF;
            4'd2:    palette = 24'hFFFF00;
            4'd3:    palette = 24'hFF00FF;
            4'd4:    palette = 24'h00FF00;
            4'd5:    palette = 24'hFF0000;
            4'd6:    palette = 24'h0000FF;
            4'd7:    palette = 24'hFF8000;
            default: palette = 24'h808080;
        endcase
    endfunction

    // Pixel stage 2: display-bank read and colour lookup
    logic [3:0]  idx_c;
    logic [23:0] rgb_d, rgb_q;
    logic        de_q;

    assign idx_c = disp_sel_q ? bank1_q[s1_addr_q] : bank0_q[s1_addr_q];

    always_comb begin
        rgb_d = '0;
        if (s1_de_q) begin
            if (!s1_inside_q) rgb_d = BORDER_RGB;
`ifdef GRID_LINE_EN
            else if ((idx_c == 4'd0) && s1_grid_q) rgb_d = GRID_RGB;
`endif
            else rgb_d = palette(idx_c);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_q <= '0;
            de_q  <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            de_q  <= s1_de_q;
        end
    end

    assign o_busy       = busy_q;
    assign o_commit_ack = ack_q;
    assign o_r          = rgb_q[23:16];
    assign o_g          = rgb_q[15:8];
    assign o_b          = rgb_q[7:0];
    assign o_de         = de_q;

endmodule

// File: tb/tb_tetris_board_render.sv
// Self-checking bench for tetris_board_render: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_tetris_board_render;

    logic       clk;
    logic       rst_n;
    logic [9:0] x, y;
    logic       de, frame_start, wr_en, commit;
    logic [3:0] wr_col, wr_color;
    logic [4:0] wr_row;
    logic       busy, ack, o_de;
    logic [7:0] r, g, b;

    int n_cmp = 0;
    int n_err = 0;

    tetris_board_render dut (
        .clk(clk), .rst_n(rst_n),
        .i_x(x), .i_y(y), .i_de(de), .i_frame_start(frame_start),
        .i_wr_en(wr_en), .i_wr_col(wr_col), .i_wr_row(wr_row), .i_wr_color(wr_color),
        .i_commit(commit), .o_busy(busy), .o_commit_ack(ack),
        .o_r(r), .o_g(g), .o_b(b), .o_de(o_de)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          bank [2][200];
    int          sel, clear_left;
    bit          pending, model_ok;
    int          s_x, s_y;
    bit          s_de;
    logic [23:0] exp_rgb;
    bit          exp_de, exp_busy, exp_ack, exp_px_valid;

    function automatic logic [23:0] pal(input int idx);
        case (idx)
            0: return 24'h000000;  1: return 24'h00FFFF;
            2: return 24'hFFFF00;  3: return 24'hFF00FF;
            4: return 24'h00FF00;  5: return 24'hFF0000;
            6: return 24'h0000FF;  7: return 24'hFF8000;
            default: return 24'h808080;
        endcase
    endfunction

    function automatic bit on_board(input int px, input int py, input bit pde);
        return pde && px >= 240 && px < 400 && py >= 80 && py < 400;
    endfunction

    function automatic logic [23:0] model_pix(input int px, input int py, input bit pde);
        int dx, dy, idx;
        if (!pde) return 24'h0;
        if (!on_board(px, py, pde)) return 24'h202020;
        dx  = px - 240;
        dy  = py - 80;
        idx = bank[sel][(dy / 16) * 10 + dx / 16];
`ifdef GRID_LINE_EN
        if (idx == 0 && (dx % 16 == 0 || dy % 16 == 0)) return 24'h404040;
`endif
        return pal(idx);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            clear_left = 200; pending = 0; sel = 0; s_de = 0;
            exp_rgb = 0; exp_de = 0; exp_busy = 1; exp_ack = 0;
            exp_px_valid = 1; model_ok = 1;
        end else begin
            // pixel produced this edge uses the board as it stood before the edge
            exp_rgb      = model_pix(s_x, s_y, s_de);
            exp_de       = s_de;
            exp_px_valid = !on_board(s_x, s_y, s_de) || clear_left == 0;
            s_x = int'(x); s_y = int'(y); s_de = de;
            exp_ack = 0;
            if (clear_left > 0) begin
                bank[0][200 - clear_left] = 0;
                bank[1][200 - clear_left] = 0;
                clear_left--;
            end else if (!pending) begin
                if (wr_en && wr_col < 10 && wr_row < 20)
                    bank[1 - sel][int'(wr_row) * 10 + int'(wr_col)] = int'(wr_color);
                if (commit) pending = 1;
            end else if (frame_start) begin
                sel = 1 - sel; pending = 0; exp_ack = 1;
            end
            exp_busy = clear_left > 0 || pending;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("o_de", 32'(o_de), 32'(exp_de));
            check("o_busy", 32'(busy), 32'(exp_busy));
            check("o_commit_ack", 32'(ack), 32'(exp_ack));
            if (exp_px_valid) check("rgb", 32'({r, g, b}), 32'(exp_rgb));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic px(input string name, input int px_x, input int px_y, input bit pde,
                      input logic [23:0] exp);
        @(negedge clk);
        x = 10'(px_x); y = 10'(px_y); de = pde;
        @(negedge clk);
        @(negedge clk);
        check(name, 32'({r, g, b}), 32'(exp));
        check({name, "_de"}, 32'(o_de), 32'(pde));
    endtask

    task automatic swap_frame(input string name);
        @(negedge clk); frame_start = 1;
        @(negedge clk); frame_start = 0;
        check(name, 32'(ack), 32'd1);
        @(negedge clk);
        check({name, "_pulse_end"}, 32'(ack), 32'd0);
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic write_cell(input int col, input int row, input int color, input bit cm);
        @(negedge clk);
        wr_en = 1; wr_col = 4'(col); wr_row = 5'(row); wr_color = 4'(color); commit = cm;
        @(negedge clk);
        wr_en = 0; commit = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        logic [23:0] grid_or_black;
        rst_n = 0; x = 0; y = 0; de = 0; frame_start = 0;
        wr_en = 0; wr_col = 0; wr_row = 0; wr_color = 0; commit = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_rgb", 32'({r, g, b}), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);

        // busy exactly 200 cycles after reset release
        rst_n = 1;
        cnt = busy ? 1 : 0;
        for (int i = 0; i < 400 && busy; i++) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        check("clear_cycles", 32'(cnt), 32'd200);

        px("cleared_cell", 300, 205, 1, 24'h000000);
        px("outside", 100, 10, 1, 24'h202020);

        // write + commit in one cycle, then swap
        write_cell(3, 5, 5, 1);
        check("pending_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        check("pending_hold", 32'(busy), 32'd1);
        swap_frame("ack1");
        px("cell_3_5", 290, 165, 1, 24'hFF0000);

        // blanking and board edges
        px("blank", 300, 200, 0, 24'h000000);
        px("edge_left_out", 239, 165, 1, 24'h202020);
`ifdef GRID_LINE_EN
        grid_or_black = 24'h404040;
`else
        grid_or_black = 24'h000000;
`endif
        px("edge_left_in", 240, 165, 1, grid_or_black);

        // write while pending is dropped
        @(negedge clk); commit = 1;
        @(negedge clk); commit = 0;
        wr_en = 1; wr_col = 3; wr_row = 5; wr_color = 2;
        @(negedge clk); wr_en = 0;
        check("drop_busy", 32'(busy), 32'd1);
        swap_frame("ack2");
        px("dropped_write", 290, 165, 1, 24'h000000);

        // commit coincident with frame start swaps one frame later
        @(negedge clk); commit = 1; frame_start = 1;
        @(negedge clk); commit = 0; frame_start = 0;
        check("coincident_no_ack", 32'(ack), 32'd0);
        check("coincident_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        swap_frame("ack3");

        // grid lines on empty cells; filled cells keep their colour
        px("grid_dx16", 256, 85, 1, grid_or_black);
        px("grid_dx17", 257, 85, 1, 24'h000000);
        write_cell(1, 0, 4, 1);
        swap_frame("ack4");
        px("filled_dx16", 256, 85, 1, 24'h00FF00);
        px("last_cell_edge", 399, 399, 1, 24'h000000);
        px("below_board", 300, 400, 1, 24'h202020);

        // randomized traffic checked against the model every cycle
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            rst_n       = ($urandom_range(0, 2499) != 0);
            de          = ($urandom_range(0, 9) != 0);
            x           = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 639))
                                                      : 10'($urandom_range(200, 440));
            y           = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 479))
                                                      : 10'($urandom_range(60, 420));
            wr_en       = ($urandom_range(0, 2) == 0);
            wr_col      = 4'($urandom_range(0, 11));
            wr_row      = 5'($urandom_range(0, 21));
            wr_color    = 4'($urandom_range(0, 15));
            commit      = ($urandom_range(0, 39) == 0);
            frame_start = ($urandom_range(0, 24) == 0);
        end
        @(negedge clk);
        rst_n = 1; wr_en = 0; commit = 0; frame_start = 0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
